// File: rtl/regfile_mp_if.sv
// Write/read/clear signal bundle for the multi-port register file.
interface regfile_mp_if #(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 5,
  parameter int unsigned NRD = 2
);
  logic              clr_req;
  logic              busy;
  logic              wen0;
  logic [AW-1:0]     wraddr0;
  logic [DW-1:0]     wrdata0;
  logic              wen1;
  logic [AW-1:0]     wraddr1;
  logic [DW-1:0]     wrdata1;
  logic [NRD*AW-1:0] rdaddr;
  logic [NRD*DW-1:0] rddata;

  modport master (
    output clr_req, wen0, wraddr0, wrdata0, wen1, wraddr1, wrdata1, rdaddr,
    input  busy, rddata
  );

  modport slave (
    input  clr_req, wen0, wraddr0, wrdata0, wen1, wraddr1, wrdata1, rdaddr,
    output busy, rddata
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (port 1 has priority), NRD
// registered read ports with write-to-read bypass, optional hardwired-zero
// entry 0, and a clear sequencer that zeroes storage after reset or on
// request so the array itself carries no reset.
module regfile_mp #(
  parameter int unsigned DW       = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_mp_if.slave bus
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     mem_q [DEPTH];
  logic [NRD*DW-1:0] rddata_q, rddata_d;
  logic [AW-1:0]     ra;
  logic              we0, we1;

  // Write qualification: only in RUN, and entry 0 is read-only when hardwired
  always_comb begin
    we0 = (state_q == RUN) && bus.wen0 && !((ZERO_REG != 0) && (bus.wraddr0 == '0));
    we1 = (state_q == RUN) && bus.wen1 && !((ZERO_REG != 0) && (bus.wraddr1 == '0));
  end

  // Clear sequencer next state: sweep every entry once, then run
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage update; port 1 is written last so it wins on an address collision
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (we0) mem_q[bus.wraddr0] <= bus.wrdata0;
      if (we1) mem_q[bus.wraddr1] <= bus.wrdata1;
    end
  end

  // Read mux per port: zero entry, then port-1 bypass, port-0 bypass, storage
  always_comb begin
    rddata_d = '0;
    ra       = '0;
    if (state_q == RUN) begin
      for (int unsigned k = 0; k < NRD; k++) begin
        ra = bus.rdaddr[k*AW +: AW];
        if ((ZERO_REG != 0) && (ra == '0)) begin
          rddata_d[k*DW +: DW] = '0;
        end else if (bus.wen1 && (bus.wraddr1 == ra)) begin
          rddata_d[k*DW +: DW] = bus.wrdata1;
        end else if (bus.wen0 && (bus.wraddr0 == ra)) begin
          rddata_d[k*DW +: DW] = bus.wrdata0;
        end else begin
          rddata_d[k*DW +: DW] = mem_q[ra];
        end
      end
    end
  end

  // Registered read data, cleared asynchronously with the sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rddata_q <= '0;
    end else begin
      rddata_q <= rddata_d;
    end
  end

  assign bus.busy   = (state_q == CLEAR);
  assign bus.rddata = rddata_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a ZERO_REG=1 instance driven by the bench
// and a ZERO_REG=0 twin that mirrors the same stimulus.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.DW(32), .AW(5), .NRD(2)) bus ();
  regfile_mp_if #(.DW(32), .AW(5), .NRD(2)) bus_nz ();

  assign bus_nz.clr_req = bus.clr_req;
  assign bus_nz.wen0    = bus.wen0;
  assign bus_nz.wraddr0 = bus.wraddr0;
  assign bus_nz.wrdata0 = bus.wrdata0;
  assign bus_nz.wen1    = bus.wen1;
  assign bus_nz.wraddr1 = bus.wraddr1;
  assign bus_nz.wrdata1 = bus.wrdata1;
  assign bus_nz.rdaddr  = bus.rdaddr;

  regfile_mp #(.DW(32), .DEPTH(32), .AW(5), .NRD(2), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  regfile_mp #(.DW(32), .DEPTH(32), .AW(5), .NRD(2), .ZERO_REG(0)) u_dut_nz (
    .clk(clk), .rst_n(rst_n), .bus(bus_nz)
  );

  typedef struct {
    logic        w0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        w1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.clr_req = 1'b0;
    bus.wen0    = 1'b0;
    bus.wraddr0 = '0;
    bus.wrdata0 = '0;
    bus.wen1    = 1'b0;
    bus.wraddr1 = '0;
    bus.wrdata1 = '0;
  endtask

  function automatic logic [31:0] rd(input int unsigned k);
    logic [63:0] v;
    v = bus.rddata;
    return v[k*32 +: 32];
  endfunction

  function automatic logic [31:0] rdnz(input int unsigned k);
    logic [63:0] v;
    v = bus_nz.rddata;
    return v[k*32 +: 32];
  endfunction

  // Steps until busy drops (bounded); reports cycle count and whether every
  // read port of both instances stayed zero the whole time.
  task automatic count_busy(input string nm);
    int   n;
    logic zero_ok;
    n = 0;
    zero_ok = 1'b1;
    do begin
      step();
      n++;
      if (bus.rddata !== 64'h0 || bus_nz.rddata !== 64'h0) zero_ok = 1'b0;
    end while (bus.busy && n < 100);
    chk({nm, "_cycles"}, 32'(n), 32'd32);
    chk({nm, "_rd_zero"}, {31'b0, zero_ok}, 32'd1);
    chk({nm, "_nz_busy"}, {31'b0, bus_nz.busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string nm);
    logic [31:0] worst;
    worst = '0;
    for (int a = 0; a < 32; a++) begin
      bus.rdaddr = {5'(31 - a), 5'(a)};
      step();
      worst = worst | rd(0) | rd(1) | rdnz(0) | rdnz(1);
    end
    chk(nm, worst, 32'h0);
  endtask

  initial begin
    vt[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0,  32'h0,       5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
    vt[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,       5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7,  32'h22222222, 5'd7, 5'd7,  32'h22222222, 32'h22222222};
    vt[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,       5'd7,  5'd5,  32'h22222222, 32'hDEADBEEF};
    vt[4]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd0,  32'h0,        32'h0};
    vt[5]  = '{1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd4,  32'h5A5A5A5A, 5'd3, 5'd4,  32'hA5A5A5A5, 32'h5A5A5A5A};
    vt[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3,  32'h12345678, 5'd3, 5'd4,  32'h12345678, 32'h5A5A5A5A};
    vt[7]  = '{1'b1, 5'd3, 32'hCAFEF00D, 1'b0, 5'd0,  32'h0,       5'd3,  5'd31, 32'hCAFEF00D, 32'h0};
    vt[8]  = '{1'b1, 5'd9, 32'h00000001, 1'b1, 5'd10, 32'h00000002, 5'd10, 5'd9, 32'h00000002, 32'h00000001};
    vt[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,       5'd0,  5'd3,  32'h0,        32'hCAFEF00D};
    vt[10] = '{1'b1, 5'd5, 32'h0,        1'b0, 5'd0,  32'h0,       5'd5,  5'd7,  32'h0,        32'h22222222};

    // Reset held: busy high, read data zero
    idle();
    bus.rdaddr = '0;
    rst_n = 1'b0;
    step();
    step();
    chk("reset_busy", {31'b0, bus.busy}, 32'd1);
    chk("reset_rd0", rd(0), 32'h0);
    chk("reset_rd1", rd(1), 32'h0);
    rst_n = 1'b1;
    count_busy("init_clear");
    check_all_zero("init_all_zero");

    // Table-driven single-cycle vectors
    for (int i = 0; i < 11; i++) begin
      bus.wen0    = vt[i].w0;
      bus.wraddr0 = vt[i].a0;
      bus.wrdata0 = vt[i].d0;
      bus.wen1    = vt[i].w1;
      bus.wraddr1 = vt[i].a1;
      bus.wrdata1 = vt[i].d1;
      bus.rdaddr  = {vt[i].r1, vt[i].r0};
      step();
      chk($sformatf("vec%0d_p0", i), rd(0), vt[i].e0);
      chk($sformatf("vec%0d_p1", i), rd(1), vt[i].e1);
    end
    idle();

    // Entry 0: hardwired zero versus ordinary register
    bus.wen0 = 1'b1; bus.wraddr0 = 5'd0; bus.wrdata0 = 32'hFFFFFFFF;
    bus.wen1 = 1'b1; bus.wraddr1 = 5'd0; bus.wrdata1 = 32'hFFFFFFFF;
    bus.rdaddr = {5'd0, 5'd0};
    step();
    chk("zero_bypass", rd(0) | rd(1), 32'h0);
    chk("nz_r0_bypass", rdnz(1), 32'hFFFFFFFF);
    idle();
    step();
    chk("zero_stored", rd(0), 32'h0);
    chk("nz_r0_stored", rdnz(0), 32'hFFFFFFFF);

    // Fill r1..r31 with their index
    for (int i = 1; i < 32; i++) begin
      bus.wen0 = 1'b1; bus.wraddr0 = 5'(i); bus.wrdata0 = 32'(i);
      step();
    end
    idle();
    bus.rdaddr = {5'd31, 5'd17};
    step();
    chk("fill_r17", rd(0), 32'd17);
    chk("fill_r31", rd(1), 32'd31);

    // Clear request with a same-cycle write that must still be wiped
    bus.clr_req = 1'b1;
    bus.wen0 = 1'b1; bus.wraddr0 = 5'd2; bus.wrdata0 = 32'h00000BAD;
    bus.rdaddr = {5'd2, 5'd17};
    step();
    chk("clr_busy", {31'b0, bus.busy}, 32'd1);
    chk("clr_cycle_rd_r17", rd(0), 32'd17);
    chk("clr_cycle_bypass_r2", rd(1), 32'h00000BAD);
    idle();
    bus.wen0 = 1'b1; bus.wraddr0 = 5'd6; bus.wrdata0 = 32'h0000EEEE;
    bus.wen1 = 1'b1; bus.wraddr1 = 5'd8; bus.wrdata1 = 32'h00008888;
    bus.rdaddr = {5'd8, 5'd6};
    count_busy("req_clear");
    idle();
    check_all_zero("req_all_zero");

    // Reset during the 10th clear cycle restarts the full sweep
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    repeat (9) step();
    rst_n = 1'b0;
    #1;
    chk("midclr_rst_busy", {31'b0, bus.busy}, 32'd1);
    step();
    step();
    chk("midclr_rst_rd", rd(0) | rd(1), 32'h0);
    rst_n = 1'b1;
    count_busy("midclr_restart");

    // Reset during RUN clears read data asynchronously
    bus.wen0 = 1'b1; bus.wraddr0 = 5'd12; bus.wrdata0 = 32'h00000077;
    bus.rdaddr = {5'd12, 5'd12};
    step();
    chk("run_r12_bypass", rd(0), 32'h00000077);
    idle();
    step();
    chk("run_r12_stored", rd(1), 32'h00000077);
    #2;
    rst_n = 1'b0;
    #1;
    chk("run_rst_async_rd", rd(0) | rd(1), 32'h0);
    chk("run_rst_busy", {31'b0, bus.busy}, 32'd1);
    step();
    rst_n = 1'b1;
    count_busy("run_rst_restart");
    step();
    chk("run_rst_r12_cleared", rd(0), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
